// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t  - responder FSM states
//   DMEM_LAT_MAX  - largest supported read latency
//   WE_*          - common byte-lane write masks (byte, half, word)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } dmem_state_t;

  localparam int DMEM_LAT_MAX = 4;
  localparam int NUM_LANES    = 4;

  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: single-port 2^ADDR_WIDTH x 32 array with per-byte-lane write
// enables and a registered read port (read-before-write), shaped for block
// RAM inference. Contents are never reset.
//   clk  - clock
//   we   - byte-lane write enables, bit i covers din[8i+7:8i]
//   addr - word index
//   din  - write data
//   rd   - registered read data, mem[addr] as of the previous edge
module dmem_bram
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic [NUM_LANES-1:0]  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           rd
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (we[l]) mem[addr][8*l +: 8] <= din[8*l +: 8];
    end
    rd <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: far end of the core load/store port. Accepts word reads
// (load) and byte-lane writes (data_we), serves them from dmem_bram and
// answers each with a one-cycle memory_done pulse.
//   clk, rstn   - clock, async active-low reset
//   addr        - byte address ([1:0] ignored)
//   din         - write data, stored verbatim
//   data_we     - byte-lane write enables, nonzero = write request
//   load        - read request (level)
//   dout        - read data, held until the next read response
//   memory_done - one-cycle completion pulse
//   err         - sticky: out-of-range access or load/write collision
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  data_we,
  input  logic        load,
  output logic [31:0] dout,
  output logic        memory_done,
  output logic        err
);

  localparam int CW = $clog2(DMEM_LAT_MAX);
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

  dmem_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] idx_q, bram_addr;
  logic [31:0] bram_rd;
  logic [3:0]  bram_we;
  logic rd_q, oor_q, oor, wr_req, accept;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];
  assign oor    = |addr[31:ADDR_WIDTH+2];
  assign wr_req = |data_we;
  assign accept = (state == IDLE) && (wr_req || load);

  // The array sees the live address only in IDLE (accept edge); afterwards
  // it keeps re-reading the latched word so its output register holds the
  // requested data whenever RESP is reached, for any latency.
  assign bram_addr = (state == IDLE) ? addr[ADDR_WIDTH+1:2] : idx_q;
  assign bram_we   = ((state == IDLE) && !oor) ? data_we : 4'b0000;

  dmem_bram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
    .clk  (clk),
    .we   (bram_we),
    .addr (bram_addr),
    .din  (din),
    .rd   (bram_rd)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (wr_req) begin
          state_n = RESP;
        end else if (load) begin
          if (READ_LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = READ;
            cnt_n   = CNT_INIT;
          end
        end
      end
      READ: begin
        // counter reaching zero on this edge ends the wait
        if (cnt <= CW'(1)) begin
          cnt_n   = '0;
          state_n = RESP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: state_n = HOLD;
      HOLD: if (!load && !wr_req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      rd_q        <= 1'b0;
      oor_q       <= 1'b0;
      dout        <= '0;
      memory_done <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      // RESP lasts one cycle, so the registered pulse is one cycle wide
      memory_done <= (state == RESP);
      if (accept) begin
        idx_q <= addr[ADDR_WIDTH+1:2];
        rd_q  <= !wr_req;
        oor_q <= oor;
        if (oor || (load && wr_req)) err <= 1'b1;
      end
      if ((state == RESP) && rd_q) dout <= oor_q ? 32'h0 : bram_rd;
    end
  end

endmodule
